// File: rtl/shift_issue_stage.sv
// Two-stage issue/retire wrapper around a 32-bit SRL-only shifter core.
// SLL is built by bit reversal around the core; SRA by sign-fill masking.
module shift_issue_stage #(
  parameter int CNT_W     = 16,
  parameter bit BIG_CLAMP = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_amt,
  output logic [31:0]      core_a,
  output logic [31:0]      core_movement,
  input  logic [31:0]      core_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_zero,
  output logic             out_err,
  output logic [CNT_W-1:0] done_cnt
);

  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  logic        s1_valid;
  logic [1:0]  s1_op;
  logic [4:0]  s1_amt;
  logic        s1_big;
  logic        s1_sign;
  logic        accept;
  logic        s2_load;
  logic        is_sll;
  logic        is_sra;
  logic [31:0] sra_fill;
  logic [31:0] res;

  assign s2_load       = s1_valid & (~out_valid | out_ready);
  assign in_ready      = ~s1_valid | s2_load;
  assign accept        = in_valid & in_ready;
  assign core_movement = {27'b0, s1_amt};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= 2'b00;
      s1_amt   <= 5'd0;
      s1_big   <= 1'b0;
      s1_sign  <= 1'b0;
      core_a   <= 32'd0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_op    <= in_op;
      s1_amt   <= in_amt[4:0];
      s1_big   <= BIG_CLAMP & (|in_amt[31:5]);
      s1_sign  <= in_a[31];
      core_a   <= (in_op == OP_SLL) ? rev32(in_a) : in_a;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  assign is_sll   = (s1_op == OP_SLL);
  assign is_sra   = (s1_op == OP_SRA);
  assign sra_fill = s1_sign ? ~(32'hFFFF_FFFF >> s1_amt) : 32'd0;

  always_comb begin
    res = core_out;
    unique case (1'b1)
      s1_big && is_sra:   res = {32{s1_sign}};
      s1_big && !is_sra:  res = 32'd0;
      !s1_big && is_sll:  res = rev32(core_out);
      !s1_big && is_sra:  res = core_out | sra_fill;
      default:            res = core_out;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= 32'd0;
      out_zero   <= 1'b0;
      out_err    <= 1'b0;
    end else if (s2_load) begin
      out_valid  <= 1'b1;
      out_result <= res;
      out_zero   <= (res == 32'd0);
      out_err    <= (s1_op == OP_RSV);
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      done_cnt <= '0;
    else if (out_valid & out_ready)
      done_cnt <= done_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed bench for shift_issue_stage: vector table, streaming,
// backpressure and reset-in-flight sequences against two clamp settings.
module tb_shift_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_op = 2'b00;
  logic [31:0] in_a = 32'd0;
  logic [31:0] in_amt = 32'd0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_zero, out_err;
  logic [31:0] core_a, core_movement, core_out, out_result;
  logic [15:0] done_cnt;

  logic        in_ready0, out_valid0, out_zero0, out_err0;
  logic [31:0] core_a0, core_movement0, core_out0, out_result0;
  logic [15:0] done_cnt0;

  always #5 clk = ~clk;

  assign core_out  = core_a >> core_movement;
  assign core_out0 = core_a0 >> core_movement0;

  shift_issue_stage #(.CNT_W(16), .BIG_CLAMP(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_amt(in_amt),
    .core_a(core_a), .core_movement(core_movement), .core_out(core_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_err(out_err),
    .done_cnt(done_cnt)
  );

  shift_issue_stage #(.CNT_W(16), .BIG_CLAMP(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready0),
    .in_op(in_op), .in_a(in_a), .in_amt(in_amt),
    .core_a(core_a0), .core_movement(core_movement0), .core_out(core_out0),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_result(out_result0), .out_zero(out_zero0), .out_err(out_err0),
    .done_cnt(done_cnt0)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] amt);
    logic big;
    big = (amt >= 32);
    case (op)
      2'b01:   return big ? 32'd0 : a << amt[4:0];
      2'b10:   return big ? {32{a[31]}} : 32'($signed(a) >>> amt[4:0]);
      default: return big ? 32'd0 : a >> amt[4:0];
    endcase
  endfunction

  // Scoreboard for streaming tests
  logic        mon_en = 1'b0;
  logic [31:0] expq[$];
  int          ret_cnt = 0;
  int          first_cyc = 0;
  int          last_cyc = 0;
  int          cyc = 0;
  logic        saw_stall = 1'b0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_res = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_hold) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_result", out_result, prev_res);
      end
      prev_hold = out_valid && !out_ready;
      prev_res  = out_result;
      if (!in_ready) saw_stall = 1'b1;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk("stream_unexpected", 32'd1, 32'd0);
        end else begin
          chk("stream_result", out_result, expq.pop_front());
        end
        if (ret_cnt == 0) first_cyc = cyc;
        last_cyc = cyc;
        ret_cnt++;
      end
      if (in_valid && in_ready) expq.push_back(model(in_op, in_a, in_amt));
    end
  end

  task automatic push_req(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] amt);
    int k;
    in_op = op; in_a = a; in_amt = amt; in_valid = 1'b1;
    k = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      k++;
      if (k > 50) begin
        chk("push_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_ret(input int n);
    int k;
    k = 0;
    while (ret_cnt < n && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("ret_count", ret_cnt, n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #2;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] amt;
    logic [31:0] e1;
    logic [31:0] e0;
    logic        err;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{2'b00, 32'hF000_0000, 32'd4,     32'h0F00_0000, 32'h0F00_0000, 1'b0};
    tbl[1]  = '{2'b01, 32'h0000_0001, 32'd31,    32'h8000_0000, 32'h8000_0000, 1'b0};
    tbl[2]  = '{2'b10, 32'h8000_0000, 32'd4,     32'hF800_0000, 32'hF800_0000, 1'b0};
    tbl[3]  = '{2'b10, 32'h8000_0001, 32'd40,    32'hFFFF_FFFF, 32'hFF80_0000, 1'b0};
    tbl[4]  = '{2'b00, 32'h8000_0001, 32'd40,    32'h0000_0000, 32'h0080_0000, 1'b0};
    tbl[5]  = '{2'b11, 32'h0000_00FF, 32'd4,     32'h0000_000F, 32'h0000_000F, 1'b1};
    tbl[6]  = '{2'b10, 32'h7FFF_FFFF, 32'd4,     32'h07FF_FFFF, 32'h07FF_FFFF, 1'b0};
    tbl[7]  = '{2'b01, 32'h1234_5678, 32'd0,     32'h1234_5678, 32'h1234_5678, 1'b0};
    tbl[8]  = '{2'b01, 32'h8000_0001, 32'd33,    32'h0000_0000, 32'h0000_0002, 1'b0};
    tbl[9]  = '{2'b10, 32'h8000_0000, 32'd31,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    tbl[10] = '{2'b00, 32'hFFFF_FFFF, 32'd32,    32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
    tbl[11] = '{2'b10, 32'hC000_0000, 32'h100,   32'hFFFF_FFFF, 32'hC000_0000, 1'b0};

    // Reset values while held in reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_flags", {30'd0, out_zero, out_err}, 32'd0);
    chk("rst_done_cnt", {16'd0, done_cnt}, 32'd0);
    chk("rst_core_a", core_a, 32'd0);
    chk("rst_core_mov", core_movement, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #2;

    // Vector table, one request at a time
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_op = tbl[i].op; in_a = tbl[i].a; in_amt = tbl[i].amt;
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("v%0d_lat1", i), {31'd0, out_valid}, 32'd0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("v%0d_lat2", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d_res", i), out_result, tbl[i].e1);
      chk($sformatf("v%0d_zero", i), {31'd0, out_zero},
          {31'd0, tbl[i].e1 == 32'd0});
      chk($sformatf("v%0d_err", i), {31'd0, out_err}, {31'd0, tbl[i].err});
      chk($sformatf("v%0d_res_noclamp", i), out_result0, tbl[i].e0);
      #1;
    end
    @(posedge clk); #1;
    chk("tbl_done_cnt", {16'd0, done_cnt}, 32'd12);
    chk("tbl_drained", {31'd0, out_valid}, 32'd0);
    #1;

    // Reset with two requests in flight
    out_ready = 1'b0;
    push_req(2'b00, 32'hAAAA_5555, 32'd3);
    push_req(2'b10, 32'h8000_0000, 32'd7);
    chk("inflight_full", {30'd0, out_valid, in_ready}, 32'd2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("inrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("inrst_done_cnt", {16'd0, done_cnt}, 32'd0);
    chk("inrst_out_result", out_result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("inrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("inrst_still_empty", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #2;

    // Back-to-back stream, no backpressure
    do_reset();
    out_ready = 1'b1;
    ret_cnt = 0; prev_hold = 1'b0; mon_en = 1'b1;
    for (int i = 0; i < 5; i++)
      push_req(2'(i % 3), 32'h8765_4321 + 32'(i) * 32'h1111_0101,
               (i == 1) ? 32'd40 : 32'(i * 7));
    wait_ret(5);
    chk("stream_consecutive", last_cyc - first_cyc, 32'd4);
    @(posedge clk); #1;
    chk("stream_done_cnt", {16'd0, done_cnt}, 32'd5);
    chk("stream_q_empty", expq.size(), 32'd0);
    mon_en = 1'b0;
    #1;

    // Stream with a 3-cycle output stall
    do_reset();
    out_ready = 1'b1;
    ret_cnt = 0; prev_hold = 1'b0; saw_stall = 1'b0; mon_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 5; i++)
          push_req(2'(i % 4), 32'hF0F0_1234 ^ (32'(i) << 28),
                   (i == 2) ? 32'd33 : 32'(i * 5 + 1));
      end
      begin
        int k;
        k = 0;
        while (ret_cnt < 1 && k < 50) begin
          @(negedge clk);
          k++;
        end
        @(posedge clk); #2;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2 out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("release_out_valid", {31'd0, out_valid}, 32'd1);
      end
    join
    wait_ret(5);
    chk("stall_seen", {31'd0, saw_stall}, 32'd1);
    @(posedge clk); #1;
    chk("stall_done_cnt", {16'd0, done_cnt}, 32'd5);
    chk("stall_q_empty", expq.size(), 32'd0);
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
